// File: rtl/wave_voice_scheduler.sv
// Shares one waveform lookup among NUM_VOICES oscillator voices. Each sample tick
// issues every voice's phase in turn, advances the accumulators and mixes the returns.
module wave_voice_scheduler #(
   parameter int NUM_VOICES = 4,
   parameter int VW         = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_sample_tick,
   input  logic [NUM_VOICES-1:0]      i_voice_en,
   input  logic [16*NUM_VOICES-1:0]   i_phase_inc,
   output logic [15:0]                o_addr,
   input  logic signed [15:0]         i_data,
   output logic signed [15:0]         o_sample,
   output logic                       o_sample_valid,
   output logic                       o_busy,
   output logic                       o_overrun
);

   localparam int AW = 16 + VW;
   localparam logic [VW-1:0] LAST_IDX = VW'(NUM_VOICES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [VW-1:0]       r_idx;
   logic [VW-1:0]       w_idx_next;
   logic [VW-1:0]       w_load_idx;
   logic                w_load;
   logic                w_capture;
   logic                w_finish;

   logic [15:0]         w_phase [NUM_VOICES];
   logic [15:0]         w_inc   [NUM_VOICES];

   logic [15:0]         r_addr;
   logic                r_addr_en;
   logic                r_data_en;
   logic signed [AW-1:0] r_acc;
   logic signed [AW-1:0] w_contrib;
   logic signed [AW-1:0] w_sum;
   logic signed [15:0]  r_sample;
   logic                r_sample_valid;
   logic                r_overrun;

   // r_idx is the voice currently presented on o_addr; loads happen one cycle ahead.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_load       = 1'b0;
      w_load_idx   = '0;
      w_capture    = 1'b0;
      w_finish     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_sample_tick) begin
               w_load       = 1'b1;
               w_load_idx   = '0;
               w_idx_next   = '0;
               w_state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // The return for voice r_idx-1 is on i_data now; voice 0 has nothing back yet.
            w_capture = (r_idx != '0);
            if (r_idx == LAST_IDX) begin
               w_state_next = S_DRAIN;
            end else begin
               w_load     = 1'b1;
               w_load_idx = r_idx + VW'(1);
               w_idx_next = r_idx + VW'(1);
            end
         end
         S_DRAIN: begin
            w_finish     = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
         logic [15:0] r_phase;

         assign w_inc[gi]   = i_phase_inc[16*gi +: 16];
         assign w_phase[gi] = r_phase;

         // A disabled voice is hard-synced back to phase 0 when its slot is issued.
         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               r_phase <= '0;
            end else if (w_load && (w_load_idx == VW'(gi))) begin
               r_phase <= i_voice_en[gi] ? (r_phase + w_inc[gi]) : 16'h0000;
            end
         end
      end
   endgenerate

   assign w_contrib = r_data_en ? {{VW{i_data[15]}}, i_data} : '0;
   assign w_sum     = r_acc + w_contrib;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_addr         <= '0;
         r_addr_en      <= 1'b0;
         r_data_en      <= 1'b0;
         r_acc          <= '0;
         r_sample       <= '0;
         r_sample_valid <= 1'b0;
         r_overrun      <= 1'b0;
      end else begin
         if (w_load) begin
            r_addr <= w_phase[w_load_idx];
         end
         // Enable travels one stage behind the address to match the lookup latency.
         r_addr_en <= w_load & i_voice_en[w_load_idx];
         r_data_en <= r_addr_en;

         if (r_state == S_IDLE) begin
            r_acc <= '0;
         end else if (w_capture) begin
            r_acc <= w_sum;
         end

         r_sample_valid <= w_finish;
         if (w_finish) begin
            r_sample <= 16'(w_sum >>> VW);
         end

         if (i_sample_tick && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign o_addr         = r_addr;
   assign o_sample       = r_sample;
   assign o_sample_valid = r_sample_valid;
   assign o_busy         = (r_state != S_IDLE);
   assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_wave_voice_scheduler.sv
// Bench for wave_voice_scheduler: square-wave lookup model, constant vector table,
// hand-written overrun/abort sequences and a randomized run against a frame-level model.
module tb_wave_voice_scheduler;

   localparam int N  = 4;
   localparam int VW = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               tick = 1'b0;
   logic [N-1:0]       en = '0;
   logic [16*N-1:0]    inc = '0;
   logic [15:0]        o_addr;
   logic signed [15:0] lut_q = '0;
   logic signed [15:0] o_sample;
   logic               o_sample_valid;
   logic               o_busy;
   logic               o_overrun;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Waveform lookup: registered square wave, one cycle of latency.
   always_ff @(posedge clk) begin
      lut_q <= o_addr[15] ? 16'sd32767 : -16'sd32767;
   end

   wave_voice_scheduler #(.NUM_VOICES(N), .VW(VW)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_sample_tick  (tick),
      .i_voice_en     (en),
      .i_phase_inc    (inc),
      .o_addr         (o_addr),
      .i_data         (lut_q),
      .o_sample       (o_sample),
      .o_sample_valid (o_sample_valid),
      .o_busy         (o_busy),
      .o_overrun      (o_overrun)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset(input int cycles, input bit chk);
      @(negedge clk);
      rst_n = 1'b0;
      tick  = 1'b1;
      en    = '1;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (chk) begin
            check("rst_addr",    o_addr,         16'h0);
            check("rst_sample",  o_sample,       16'h0);
            check("rst_valid",   o_sample_valid, 1'b0);
            check("rst_busy",    o_busy,         1'b0);
            check("rst_overrun", o_overrun,      1'b0);
         end
      end
      tick  = 1'b0;
      en    = '0;
      rst_n = 1'b1;
   endtask

   // One tick, then watch N+6 cycles: collect slot addresses, busy length, valid timing.
   task automatic do_frame(input logic [N-1:0] f_en, input logic [16*N-1:0] f_inc,
                           output logic [15:0] smp, output logic [16*N-1:0] addrs);
      int busy_cnt;
      int valid_cnt;
      int valid_k;
      busy_cnt  = 0;
      valid_cnt = 0;
      valid_k   = -1;
      smp       = 'x;
      addrs     = 'x;
      @(negedge clk);
      en   = f_en;
      inc  = f_inc;
      tick = 1'b1;
      for (int k = 1; k <= N + 6; k++) begin
         @(negedge clk);
         tick = 1'b0;
         if (k <= N) addrs[16*(k-1) +: 16] = o_addr;
         if (o_busy) busy_cnt++;
         if (o_sample_valid) begin
            if (valid_cnt == 0) begin
               valid_k = k;
               smp     = o_sample;
            end
            valid_cnt++;
         end
      end
      check("valid_latency", 64'(valid_k),   64'(N + 2));
      check("valid_count",   64'(valid_cnt), 64'd1);
      check("busy_length",   64'(busy_cnt),  64'(N + 1));
      $display("frame en=%b inc=%h sample=%0d addrs=%h", f_en, f_inc, $signed(smp), addrs);
   endtask

   // Frame-level reference: phases as plain numbers, mix as floor of the mean.
   logic [15:0] m_phase [N];

   task automatic model_frame(input logic [N-1:0] f_en, input logic [16*N-1:0] f_inc,
                              output logic [15:0] smp, output logic [16*N-1:0] addrs);
      int sum;
      int q;
      sum = 0;
      for (int v = 0; v < N; v++) begin
         addrs[16*v +: 16] = m_phase[v];
         if (f_en[v]) begin
            sum += (m_phase[v] >= 16'h8000) ? 32767 : -32767;
            m_phase[v] = m_phase[v] + f_inc[16*v +: 16];
         end else begin
            m_phase[v] = 16'h0;
         end
      end
      if (sum >= 0) q = sum / N;
      else          q = -((-sum + N - 1) / N);
      smp = 16'(q);
   endtask

   typedef struct {
      bit              rst;
      logic [N-1:0]    en;
      logic [16*N-1:0] inc;
      int              slot;
      logic [15:0]     exp_addr;
      logic [15:0]     exp_smp;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic [15:0]     smp;
      logic [15:0]     m_smp;
      logic [16*N-1:0] addrs;
      logic [16*N-1:0] m_addrs;
      logic [N-1:0]    r_en;
      logic [16*N-1:0] r_inc;
      int              valid_q[$];
      int              nvalid;

      // Single voice at half-cycle increment.
      tbl.push_back('{1, 4'b0001, 64'h0000_0000_0000_8000, 0, 16'h0000, 16'hE000});
      tbl.push_back('{0, 4'b0001, 64'h0000_0000_0000_8000, 0, 16'h8000, 16'h1FFF});
      tbl.push_back('{0, 4'b0001, 64'h0000_0000_0000_8000, 0, 16'h0000, 16'hE000});
      // All voices, zero increment, then half-cycle increment.
      tbl.push_back('{1, 4'b1111, 64'h0,                   0, 16'h0000, 16'h8001});
      tbl.push_back('{0, 4'b1111, 64'h0,                   3, 16'h0000, 16'h8001});
      tbl.push_back('{0, 4'b1111, 64'h8000_8000_8000_8000, 2, 16'h0000, 16'h8001});
      tbl.push_back('{0, 4'b1111, 64'h8000_8000_8000_8000, 3, 16'h8000, 16'h7FFF});
      tbl.push_back('{0, 4'b1111, 64'h8000_8000_8000_8000, 1, 16'h0000, 16'h8001});
      // Quarter-cycle increment wraps 0xC000 -> 0x0000.
      tbl.push_back('{1, 4'b0001, 64'h0000_0000_0000_4000, 0, 16'h0000, 16'hE000});
      tbl.push_back('{0, 4'b0001, 64'h0000_0000_0000_4000, 0, 16'h4000, 16'hE000});
      tbl.push_back('{0, 4'b0001, 64'h0000_0000_0000_4000, 0, 16'h8000, 16'h1FFF});
      tbl.push_back('{0, 4'b0001, 64'h0000_0000_0000_4000, 0, 16'hC000, 16'h1FFF});
      tbl.push_back('{0, 4'b0001, 64'h0000_0000_0000_4000, 0, 16'h0000, 16'hE000});
      // Voice 1 disable hard-syncs its phase.
      tbl.push_back('{1, 4'b0010, 64'h0000_0000_8000_0000, 1, 16'h0000, 16'hE000});
      tbl.push_back('{0, 4'b0000, 64'h0000_0000_8000_0000, 1, 16'h8000, 16'h0000});
      tbl.push_back('{0, 4'b0010, 64'h0000_0000_8000_0000, 1, 16'h0000, 16'hE000});

      // Reset values, then all-disabled frames.
      do_reset(3, 1'b1);
      for (int i = 0; i < 2; i++) begin
         do_frame(4'b0000, 64'h1234_5678_9ABC_DEF0, smp, addrs);
         check("idle_frame_sample", smp, 16'h0);
      end

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset(2, 1'b0);
         do_frame(tbl[i].en, tbl[i].inc, smp, addrs);
         check("tbl_sample", smp, tbl[i].exp_smp);
         check("tbl_addr", addrs[16*tbl[i].slot +: 16], tbl[i].exp_addr);
      end
      check("no_overrun", o_overrun, 1'b0);

      // Overrun tick at T+3 is dropped; tick at T+N+2 starts the next frame.
      do_reset(2, 1'b0);
      @(negedge clk);
      en   = 4'b0001;
      inc  = 64'h0000_0000_0000_8000;
      tick = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (o_sample_valid) valid_q.push_back(k);
         if (k == N + 2) check("b2b_busy_low", o_busy, 1'b0);
         if (k == N + 3) check("b2b_busy_high", o_busy, 1'b1);
         tick = (k == 3) || (k == N + 2);
      end
      check("b2b_valid_count", 64'(valid_q.size()), 64'd2);
      if (valid_q.size() >= 2) begin
         check("b2b_first_valid",  64'(valid_q[0]), 64'(N + 2));
         check("b2b_second_valid", 64'(valid_q[1]), 64'(2 * N + 4));
      end
      check("overrun_set", o_overrun, 1'b1);

      // Reset during ISSUE aborts the frame and clears phases.
      do_reset(2, 1'b0);
      do_frame(4'b0001, 64'h0000_0000_0000_4000, smp, addrs);
      check("abort_pre_addr", addrs[15:0], 16'h0000);
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      nvalid = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (o_sample_valid) nvalid++;
      end
      check("abort_no_valid", 64'(nvalid), 64'd0);
      check("abort_sample",   o_sample,  16'h0);
      check("abort_addr",     o_addr,    16'h0);
      check("abort_busy",     o_busy,    1'b0);
      check("abort_overrun",  o_overrun, 1'b0);
      do_frame(4'b0001, 64'h0000_0000_0000_4000, smp, addrs);
      check("abort_phase_cleared", addrs[15:0], 16'h0000);
      check("abort_next_sample", smp, 16'hE000);

      // Randomized frames against the reference model.
      do_reset(2, 1'b0);
      for (int v = 0; v < N; v++) m_phase[v] = 16'h0;
      for (int i = 0; i < 30; i++) begin
         r_en = N'($urandom);
         for (int v = 0; v < N; v++) begin
            case ($urandom_range(0, 3))
               0:       r_inc[16*v +: 16] = 16'h0000;
               1:       r_inc[16*v +: 16] = 16'h4000;
               2:       r_inc[16*v +: 16] = 16'h8000;
               default: r_inc[16*v +: 16] = 16'($urandom);
            endcase
         end
         model_frame(r_en, r_inc, m_smp, m_addrs);
         do_frame(r_en, r_inc, smp, addrs);
         check("rand_sample", smp, m_smp);
         for (int v = 0; v < N; v++) begin
            check("rand_addr", addrs[16*v +: 16], m_addrs[16*v +: 16]);
         end
      end
      check("rand_no_overrun", o_overrun, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wave_voice_scheduler.md
Name: wave_voice_scheduler

Overview:
- Time-multiplexes one shared waveform lookup block among NUM_VOICES oscillator voices.
- The lookup block has a 16-bit address in, a signed 16-bit registered sample out, and 1-cycle latency.
- On each sample-rate tick the block does three things:
  - issues each voice's phase to the lookup, one voice per clock;
  - advances that voice's phase accumulator;
  - sums the returned samples of enabled voices and outputs their scaled average as one mixed sample.
- It sits between the sample-rate timebase and the DAC/output formatter.

Parameters:
- NUM_VOICES, 4, number of voices; power of two, 2..16.
- VW, 2, log2(NUM_VOICES); must be consistent with NUM_VOICES.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_sample_tick  input  1  one-cycle pulse that requests one mixing frame.
- i_voice_en  input  NUM_VOICES  per-voice enable; bit v belongs to voice v.
- i_phase_inc  input  16*NUM_VOICES  per-voice phase increment; voice v uses bits [16v+15:16v], unsigned.
- o_addr  output  16  registered address to the waveform lookup.
- i_data  input  16  signed sample from the waveform lookup; valid 1 cycle after the matching o_addr.
- o_sample  output  16  signed mixed sample, registered.
- o_sample_valid  output  1  one-cycle pulse; o_sample updated.
- o_busy  output  1  high while a frame is in progress.
- o_overrun  output  1  sticky; set when a tick arrives while busy.

Behaviour:
- Reset, sampled on a rising edge with i_rst_n=0:
  - o_addr=0, o_sample=0, o_sample_valid=0, o_busy=0, o_overrun=0;
  - all phase accumulators=0, accumulator=0, FSM=IDLE.
- Reset mid-frame aborts the frame: no o_sample_valid pulse; o_sample stays 0.
- FSM states:
  - IDLE: waits for i_sample_tick=1 → ISSUE, voice index=0.
  - ISSUE: one voice per cycle, voice index 0..NUM_VOICES-1; after the last voice → DRAIN.
  - DRAIN: one cycle; collects the last return → IDLE.
- Timing for a tick sampled in cycle T (FSM in IDLE):
  - o_addr = phase[v] during cycle T+1+v, for v=0..N-1.
  - i_data for voice v is captured in cycle T+2+v.
  - o_sample and o_sample_valid=1 appear in cycle T+N+2 only.
  - o_busy=1 in cycles T+1..T+N+1, and 0 in cycle T+N+2.
- Issue of voice v:
  - i_voice_en[v] is sampled in the cycle before o_addr presents voice v (the cycle the register loads).
  - The sampled enable bit is delayed alongside the lookup latency to qualify the returned i_data.
  - If enabled, the pre-increment phase is issued and phase[v] <= phase[v] + inc[v], modulo 2^16 with silent wrap.
  - If disabled, o_addr is still driven with phase[v], and phase[v] is cleared to 0 (hard sync). Its returned data contributes 0.
- Accumulation:
  - Accumulator width is 16+VW bits, signed, with i_data sign-extended; cleared at frame start.
  - Only qualified returns are added.
  - On the last return, o_sample <= (acc + last contribution) >>> VW, an arithmetic shift that floors toward -inf. No saturation is needed, because the result is always in range.
- An all-disabled frame still runs full length and outputs o_sample=0 with a valid pulse.
- Ticks outside IDLE:
  - i_sample_tick in any non-IDLE cycle is dropped and sets o_overrun=1 until reset.
  - A tick in cycle T+N+2 is accepted normally, so back-to-back frames have period N+2.
- i_phase_inc may change at any time; the value sampled at that voice's issue cycle is used.
- o_addr holds its last value when idle.

Test Plan:
- The bench models the lookup as a square wave: a registered output of -32767 if addr[15]=0, else +32767.
1. Reset with i_rst_n=0 for 3 cycles, then ticks with i_voice_en=0 → all outputs 0 during reset. After reset each frame gives o_sample=0 and a valid pulse exactly N+2 cycles after the tick; o_busy is high for N+1 cycles.
2. N=4, voice0 only, inc0=0x8000, 3 ticks spaced 10 cycles → o_sample = -8192, 8191, -8192. o_addr in voice0's slot = 0x0000, 0x8000, 0x0000.
3. All 4 voices enabled, all inc=0 → o_sample=-32767 every frame. Then all inc=0x8000 → -32767, +32767, -32767 alternating.
4. Voice0 only, inc=0x4000, 5 frames → -8192, -8192, 8191, 8191, -8192 (tests wrap at 0xC000→0x0000).
5. Voice1 enabled with inc=0x8000 for 1 frame, disabled for 1, re-enabled → its phase restarts at 0. Slot-1 o_addr = 0x0000, 0x8000, 0x0000; o_sample = -8192, 0, -8192.
6. A tick 3 cycles after an accepted tick → no extra frame and o_overrun=1. A tick exactly N+2 cycles after the accepted tick starts a new frame. Reset asserted during ISSUE gives no valid pulse, and all state returns to reset values.
